// File: rtl/interfpga_frame_scheduler_pkg.sv
// Shared types and constants for the inter-FPGA frame scheduler.
// Frames are [LEN][payload x LEN][CRC8], with CRC-8 poly 0x07, MSB-first and zero init.
package interfpga_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StAck,
    StDone,
    StDrain
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/interfpga_frame_scheduler_if.sv
// Byte-in / byte-out handshake bundle between the UART side, the scheduler and interfpga_send.
// The master is the environment that drives the UART strobes and models the link busy flag.
interface interfpga_frame_scheduler_if;
   logic       i_valid;
   logic [7:0] i_data;
   logic       i_flush;
   logic       i_busy;
   logic       o_send;
   logic [7:0] o_data;

   modport master (
      output i_valid, i_data, i_flush, i_busy,
      input  o_send, o_data
   );

   modport slave (
      input  i_valid, i_data, i_flush, i_busy,
      output o_send, o_data
   );
endinterface

// File: rtl/crc8_byte_update.sv
// Combinational CRC-8 step: folds one byte into a running CRC, MSB-first, no reflection.
module crc8_byte_update
   import interfpga_frame_scheduler_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [7:0] data_byte,
   output logic [7:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ data_byte;
      for (int i = 0; i < 8; i++) begin
         crc_out = crc_out[7] ? ({crc_out[6:0], 1'b0} ^ CRC8_POLY) : {crc_out[6:0], 1'b0};
      end
   end

endmodule

// File: rtl/interfpga_frame_scheduler.sv
// Buffers UART bytes in a FIFO and sends them to interfpga_send as [LEN][payload][CRC8] frames,
// one byte per send/busy handshake, aborting a frame if the link never acknowledges.
module interfpga_frame_scheduler
   import interfpga_frame_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned MAX_LEN     = 16,
   parameter int unsigned ACK_TIMEOUT = 1023
) (
   input  logic                         clk,
   input  logic                         reset,
   interfpga_frame_scheduler_if.slave   link,
   output logic                         o_full,
   output logic                         o_frame_busy,
   output logic                         o_overflow,
   output logic                         o_timeout,
   output logic [7:0]                   o_frame_count,
   output logic [7:0]                   o_crc8
);

   localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ADDR_W:0]   DepthC   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   MaxLenC  = (ADDR_W + 1)'(MAX_LEN);
   localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PtrOne   = ADDR_W'(1);
   localparam logic [TimerW-1:0] TimeoutC = TimerW'(ACK_TIMEOUT);
   localparam logic [TimerW-1:0] TimerOne = TimerW'(1);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic              wr_en, pop;
   logic [7:0]        head;

   state_e            state_q, state_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              crc_sent_q, crc_sent_d;
   logic [7:0]        crc_q, crc_d;
   logic [7:0]        data_q, data_d;
   logic [7:0]        crc8_q, crc8_d;
   logic [7:0]        frame_count_q, frame_count_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              overflow_q, overflow_d;
   logic              timeout_q, timeout_d;

   logic [7:0]        crc_src, crc_byte, crc_next;

   assign o_full = (count_q == DepthC);
   assign wr_en  = link.i_valid && !o_full;
   assign head   = mem_q[rd_ptr_q];

   // In IDLE the unit seeds the frame CRC with LEN; otherwise it folds in the FIFO head.
   assign crc_src  = (state_q == StIdle) ? CRC8_INIT : crc_q;
   assign crc_byte = (state_q == StIdle) ? 8'(count_q) : head;

   crc8_byte_update u_crc (
      .crc_in    (crc_src),
      .data_byte (crc_byte),
      .crc_out   (crc_next)
   );

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= link.i_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop)   rd_ptr_q <= rd_ptr_q + PtrOne;
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + CntOne;
            2'b01:   count_q <= count_q - CntOne;
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      remaining_d   = remaining_q;
      crc_sent_d    = crc_sent_q;
      crc_d         = crc_q;
      data_d        = data_q;
      crc8_d        = crc8_q;
      frame_count_d = frame_count_q;
      timer_d       = timer_q;
      overflow_d    = overflow_q || (link.i_valid && o_full);
      timeout_d     = timeout_q;
      pop           = 1'b0;

      case (state_q)
         StIdle: begin
            // LEN is latched here, so later writes fall into the next frame.
            if ((link.i_flush && count_q != '0) || count_q >= MaxLenC) begin
               remaining_d = count_q;
               data_d      = 8'(count_q);
               crc_d       = crc_next;
               crc_sent_d  = 1'b0;
               state_d     = StSend;
            end
         end
         StSend: begin
            timer_d = '0;
            state_d = StAck;
         end
         StAck: begin
            if (link.i_busy) begin
               state_d = StDone;
            end else if (timer_q == TimeoutC) begin
               timeout_d = 1'b1;
               state_d   = StDrain;
            end else begin
               timer_d = timer_q + TimerOne;
            end
         end
         StDone: begin
            if (!link.i_busy) begin
               if (remaining_q != '0) begin
                  data_d      = head;
                  pop         = 1'b1;
                  crc_d       = crc_next;
                  remaining_d = remaining_q - CntOne;
                  state_d     = StSend;
               end else if (!crc_sent_q) begin
                  data_d     = crc_q;
                  crc_sent_d = 1'b1;
                  state_d    = StSend;
               end else begin
                  crc8_d        = crc_q;
                  frame_count_d = frame_count_q + 8'd1;
                  state_d       = StIdle;
               end
            end
         end
         StDrain: begin
            if (remaining_q != '0) begin
               pop         = 1'b1;
               remaining_d = remaining_q - CntOne;
            end
            if (remaining_q <= CntOne) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         remaining_q   <= '0;
         crc_sent_q    <= 1'b0;
         crc_q         <= CRC8_INIT;
         data_q        <= '0;
         crc8_q        <= '0;
         frame_count_q <= '0;
         timer_q       <= '0;
         overflow_q    <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         remaining_q   <= remaining_d;
         crc_sent_q    <= crc_sent_d;
         crc_q         <= crc_d;
         data_q        <= data_d;
         crc8_q        <= crc8_d;
         frame_count_q <= frame_count_d;
         timer_q       <= timer_d;
         overflow_q    <= overflow_d;
         timeout_q     <= timeout_d;
      end
   end

   assign link.o_send   = (state_q == StSend);
   assign link.o_data   = data_q;
   assign o_frame_busy  = (state_q != StIdle);
   assign o_overflow    = overflow_q;
   assign o_timeout     = timeout_q;
   assign o_frame_count = frame_count_q;
   assign o_crc8        = crc8_q;

endmodule

// File: tb/tb_interfpga_frame_scheduler.sv
// Scoreboard bench: stimulus queues the expected link bytes; a monitor that also models
// interfpga_send (busy 2 cycles after o_send, for 20 cycles) pops and compares on each o_send.
module tb_interfpga_frame_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       o_full, o_frame_busy, o_overflow, o_timeout;
   logic [7:0] o_frame_count, o_crc8;

   interfpga_frame_scheduler_if link();

   interfpga_frame_scheduler #(
      .DEPTH       (16),
      .ADDR_W      (4),
      .MAX_LEN     (16),
      .ACK_TIMEOUT (1023)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .link          (link),
      .o_full        (o_full),
      .o_frame_busy  (o_frame_busy),
      .o_overflow    (o_overflow),
      .o_timeout     (o_timeout),
      .o_frame_count (o_frame_count),
      .o_crc8        (o_crc8)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] pl[$];
   logic [7:0] last_crc;
   logic [7:0] held;
   logic [7:0] exp_b;
   int         send_cnt = 0;
   int         age = 0;
   bit         busy_en = 1'b1;
   int         s;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] crc8_model(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
      return r;
   endfunction

   task automatic push_frame();
      logic [7:0] c;
      c = crc8_model(8'h00, 8'(pl.size()));
      exp_q.push_back(8'(pl.size()));
      foreach (pl[i]) begin
         exp_q.push_back(pl[i]);
         c = crc8_model(c, pl[i]);
      end
      exp_q.push_back(c);
      last_crc = c;
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      link.i_valid = 1'b1;
      link.i_data  = b;
      @(negedge clk);
      link.i_valid = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clk);
      link.i_flush = 1'b1;
      @(negedge clk);
      link.i_flush = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (o_frame_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", o_frame_busy, 0);
   endtask

   task automatic wait_busy(input int budget);
      int n = 0;
      while (!o_frame_busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("frame_started", o_frame_busy, 1);
   endtask

   task automatic wait_sends(input int target, input int budget);
      int n = 0;
      while (send_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("sends_reached", send_cnt >= target, 1);
   endtask

   // Link model and scoreboard monitor.
   always @(negedge clk) begin
      if (reset) begin
         age         = 0;
         link.i_busy = 1'b0;
      end else begin
         if (age > 0) begin
            age++;
            if (age == 3) link.i_busy = 1'b1;
            if (age == 23) begin
               link.i_busy = 1'b0;
               check("data_stable", link.o_data, held);
               age = 0;
            end
         end
         if (link.o_send) begin
            send_cnt++;
            held = link.o_data;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected got %0h want no send", link.o_data);
            end else begin
               exp_b = exp_q.pop_front();
               check("sb_byte", link.o_data, exp_b);
            end
            if (busy_en) age = 1;
         end
      end
   end

   initial begin
      reset        = 1'b1;
      link.i_valid = 1'b0;
      link.i_data  = 8'h00;
      link.i_flush = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_send", link.o_send, 0);
      check("rst_data", link.o_data, 0);
      check("rst_full", o_full, 0);
      check("rst_frame_busy", o_frame_busy, 0);
      check("rst_overflow", o_overflow, 0);
      check("rst_timeout", o_timeout, 0);
      check("rst_count", o_frame_count, 0);
      check("rst_crc8", o_crc8, 0);
      reset = 1'b0;

      // Frame 1 with hand-computed bytes; A5 arrives mid-frame and must wait for frame 2.
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h31);
      exp_q.push_back(8'h32);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'hFA);
      write_byte(8'h31);
      write_byte(8'h32);
      write_byte(8'h33);
      do_flush();
      check("send_at_flush_plus1", link.o_send, 1);
      wait_sends(2, 200);
      write_byte(8'hA5);
      wait_idle(400);
      check("t1_crc8", o_crc8, 8'hFA);
      check("t1_count", o_frame_count, 1);

      pl = '{8'hA5};
      push_frame();
      do_flush();
      wait_idle(400);
      check("t5_crc8", o_crc8, last_crc);
      check("t5_count", o_frame_count, 2);

      // Auto flush at MAX_LEN.
      pl.delete();
      for (int i = 0; i < 16; i++) pl.push_back(8'(i));
      push_frame();
      foreach (pl[i]) write_byte(pl[i]);
      wait_busy(10);
      wait_idle(1000);
      check("t2_crc8", o_crc8, last_crc);
      check("t2_count", o_frame_count, 3);
      check("t2_overflow", o_overflow, 0);
      s = send_cnt;
      do_flush();
      repeat (30) @(negedge clk);
      check("t2_fifo_empty_no_send", send_cnt, s);

      // Stalled link: fill the FIFO, overflow, then ACK timeout drains the 1-byte frame.
      busy_en = 1'b0;
      exp_q.push_back(8'h01);
      write_byte(8'hC0);
      do_flush();
      check("t3_send", link.o_send, 1);
      for (int i = 0; i < 16; i++) begin
         write_byte(8'hD0 + 8'(i));
         if (i == 14) begin
            check("t3_full", o_full, 1);
            check("t3_no_overflow_yet", o_overflow, 0);
         end
      end
      check("t3_overflow", o_overflow, 1);
      repeat (980) @(negedge clk);
      check("t4_no_timeout_yet", o_timeout, 0);
      check("t4_still_busy", o_frame_busy, 1);
      wait_idle(40);
      check("t4_timeout", o_timeout, 1);
      check("t4_count", o_frame_count, 3);
      check("t4_drained", o_full, 0);

      busy_en = 1'b1;
      pl.delete();
      for (int i = 0; i < 15; i++) pl.push_back(8'hD0 + 8'(i));
      push_frame();
      do_flush();
      wait_idle(1000);
      check("t4_next_crc8", o_crc8, last_crc);
      check("t4_next_count", o_frame_count, 4);
      check("t3_overflow_sticky", o_overflow, 1);

      // Reset during the second payload byte abandons the frame.
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      s = send_cnt;
      write_byte(8'h41);
      write_byte(8'h42);
      write_byte(8'h43);
      do_flush();
      wait_sends(s + 3, 200);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t6_send", link.o_send, 0);
      check("t6_frame_busy", o_frame_busy, 0);
      check("t6_full", o_full, 0);
      check("t6_count", o_frame_count, 0);
      check("t6_overflow", o_overflow, 0);
      reset = 1'b0;
      s = send_cnt;
      do_flush();
      repeat (30) @(negedge clk);
      check("t6_empty_flush_no_send", send_cnt, s);
      check("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
